// File: rtl/pi_speed_regulator.sv
// rtl/pi_speed_regulator.sv - closed-loop PI speed regulator with braked direction reversal
// Four-stage update pipeline launched by a periodic tick; the last stage also runs the reversal FSM.
module pi_speed_regulator #(
  parameter int unsigned CLOCK_HZ     = 100000000,
  parameter int unsigned UPDATE_HZ    = 1000,
  parameter int unsigned ZERO_UPDATES = 2
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        ENABLE,
  input  logic [15:0] SETPOINT_RPS,
  input  logic        DIR_RQ,
  input  logic [7:0]  KP,
  input  logic [7:0]  KI,
  input  logic [15:0] MOTOR_FB_RPS,
  output logic [7:0]  MOTOR_DC,
  output logic        DIR_SEL_RQ,
  output logic        BUSY_REVERSE
);

  localparam int unsigned PERIOD = CLOCK_HZ / UPDATE_HZ;
  localparam int CNT_W = (PERIOD > 1) ? $clog2(PERIOD) : 1;
  localparam int ZC_W  = $clog2(ZERO_UPDATES + 1);
  localparam int AW    = 28;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(PERIOD - 1);
  localparam logic [ZC_W-1:0]  ZC_LAST  = ZC_W'(ZERO_UPDATES - 1);

  typedef enum logic {ST_RUN, ST_BRAKE} state_t;

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             tick;

  logic             v1_q, v1_d, v2_q, v2_d, v3_q, v3_d;
  logic [15:0]      sp1_q, sp1_d, fb1_q, fb1_d;
  logic [7:0]       kp1_q, kp1_d, ki1_q, ki1_d, kp2_q, kp2_d, ki2_q, ki2_d;
  logic             dir1_q, dir1_d, dir2_q, dir2_d, dir3_q, dir3_d;
  logic             en1_q, en1_d, en2_q, en2_d, en3_q, en3_d;
  logic             fbz2_q, fbz2_d, fbz3_q, fbz3_d;
  logic signed [16:0]   err2_q, err2_d, err3_q, err3_d;
  logic signed [AW-1:0] pterm3_q, pterm3_d, iterm3_q, iterm3_d;

  state_t           state_q, state_d;
  logic [ZC_W-1:0]  zc_q, zc_d;
  logic [15:0]      integ_q, integ_d;
  logic [7:0]       dc_q, dc_d;
  logic             dir_sel_q, dir_sel_d;
  logic             busy_q, busy_d;

  logic signed [AW-1:0] err_x, kp_x, ki_x, integ_x, sum, u;
  logic             u_over, u_under, err_pos, err_neg, windup;
  logic [7:0]       dc_pi;
  logic [15:0]      iterm_sat;

  assign tick = (cnt_q == CNT_LAST);

  always_comb begin
    cnt_d  = tick ? '0 : cnt_q + CNT_W'(1);

    // Stage 1 samples inputs only on the tick; later stages just shift
    v1_d   = tick;
    sp1_d  = tick ? SETPOINT_RPS : sp1_q;
    fb1_d  = tick ? MOTOR_FB_RPS : fb1_q;
    kp1_d  = tick ? KP           : kp1_q;
    ki1_d  = tick ? KI           : ki1_q;
    dir1_d = tick ? DIR_RQ       : dir1_q;
    en1_d  = tick ? ENABLE       : en1_q;

    v2_d   = v1_q;
    err2_d = $signed({1'b0, sp1_q}) - $signed({1'b0, fb1_q});
    fbz2_d = (fb1_q == 16'd0);
    kp2_d  = kp1_q;
    ki2_d  = ki1_q;
    dir2_d = dir1_q;
    en2_d  = en1_q;

    err_x   = {{(AW-17){err2_q[16]}}, err2_q};
    kp_x    = $signed({{(AW-8){1'b0}}, kp2_q});
    ki_x    = $signed({{(AW-8){1'b0}}, ki2_q});
    integ_x = $signed({{(AW-16){1'b0}}, integ_q});

    v3_d     = v2_q;
    pterm3_d = err_x * kp_x;
    iterm3_d = integ_x + err_x * ki_x;
    err3_d   = err2_q;
    fbz3_d   = fbz2_q;
    dir3_d   = dir2_q;
    en3_d    = en2_q;

    sum     = pterm3_q + iterm3_q;
    u       = sum >>> 4;
    u_under = u[AW-1];
    u_over  = !u_under && (u > 28'sd255);
    err_pos = !err3_q[16] && (err3_q != 17'sd0);
    err_neg = err3_q[16];
    windup  = (u_over && err_pos) || (u_under && err_neg);
    dc_pi   = u_under ? 8'd0 : (u_over ? 8'd255 : u[7:0]);
    if (iterm3_q[AW-1])
      iterm_sat = 16'd0;
    else if (iterm3_q > 28'sd4080)
      iterm_sat = 16'd4080;
    else
      iterm_sat = iterm3_q[15:0];

    state_d   = state_q;
    zc_d      = zc_q;
    integ_d   = integ_q;
    dc_d      = dc_q;
    dir_sel_d = dir_sel_q;
    busy_d    = busy_q;

    if (v3_q) begin
      if (!en3_q) begin
        state_d = ST_RUN;
        zc_d    = '0;
        integ_d = '0;
        dc_d    = '0;
        busy_d  = 1'b0;
        // While disabled the motor is unpowered, so a stopped motor can flip at once
        if (dir3_q != dir_sel_q && fbz3_q)
          dir_sel_d = dir3_q;
      end else begin
        case (state_q)
          ST_RUN: begin
            if (dir3_q != dir_sel_q) begin
              state_d = ST_BRAKE;
              zc_d    = '0;
              integ_d = '0;
              dc_d    = '0;
              busy_d  = 1'b1;
            end else begin
              dc_d = dc_pi;
              if (!windup)
                integ_d = iterm_sat;
            end
          end
          ST_BRAKE: begin
            integ_d = '0;
            dc_d    = '0;
            if (dir3_q == dir_sel_q) begin
              state_d = ST_RUN;
              zc_d    = '0;
              busy_d  = 1'b0;
            end else if (fbz3_q) begin
              if (zc_q == ZC_LAST) begin
                state_d   = ST_RUN;
                zc_d      = '0;
                busy_d    = 1'b0;
                dir_sel_d = dir3_q;
              end else begin
                zc_d = zc_q + ZC_W'(1);
              end
            end else begin
              zc_d = '0;
            end
          end
          default: state_d = ST_RUN;
        endcase
      end
    end
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      cnt_q     <= '0;
      v1_q      <= 1'b0;
      v2_q      <= 1'b0;
      v3_q      <= 1'b0;
      sp1_q     <= '0;
      fb1_q     <= '0;
      kp1_q     <= '0;
      ki1_q     <= '0;
      dir1_q    <= 1'b1;
      en1_q     <= 1'b0;
      err2_q    <= '0;
      fbz2_q    <= 1'b0;
      kp2_q     <= '0;
      ki2_q     <= '0;
      dir2_q    <= 1'b1;
      en2_q     <= 1'b0;
      pterm3_q  <= '0;
      iterm3_q  <= '0;
      err3_q    <= '0;
      fbz3_q    <= 1'b0;
      dir3_q    <= 1'b1;
      en3_q     <= 1'b0;
      state_q   <= ST_RUN;
      zc_q      <= '0;
      integ_q   <= '0;
      dc_q      <= '0;
      dir_sel_q <= 1'b1;
      busy_q    <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      v1_q      <= v1_d;
      v2_q      <= v2_d;
      v3_q      <= v3_d;
      sp1_q     <= sp1_d;
      fb1_q     <= fb1_d;
      kp1_q     <= kp1_d;
      ki1_q     <= ki1_d;
      dir1_q    <= dir1_d;
      en1_q     <= en1_d;
      err2_q    <= err2_d;
      fbz2_q    <= fbz2_d;
      kp2_q     <= kp2_d;
      ki2_q     <= ki2_d;
      dir2_q    <= dir2_d;
      en2_q     <= en2_d;
      pterm3_q  <= pterm3_d;
      iterm3_q  <= iterm3_d;
      err3_q    <= err3_d;
      fbz3_q    <= fbz3_d;
      dir3_q    <= dir3_d;
      en3_q     <= en3_d;
      state_q   <= state_d;
      zc_q      <= zc_d;
      integ_q   <= integ_d;
      dc_q      <= dc_d;
      dir_sel_q <= dir_sel_d;
      busy_q    <= busy_d;
    end
  end

  assign MOTOR_DC     = dc_q;
  assign DIR_SEL_RQ   = dir_sel_q;
  assign BUSY_REVERSE = busy_q;

endmodule

// File: tb/tb_pi_speed_regulator.sv
// tb/tb_pi_speed_regulator.sv - scoreboard bench for pi_speed_regulator
// A tick-level reference model pushes expected outputs at each latch edge; they are popped 3 edges later.
`timescale 1ns/1ps
module tb_pi_speed_regulator;

  logic        CLK = 1'b0;
  logic        RESET = 1'b0;
  logic        ENABLE = 1'b0;
  logic [15:0] SETPOINT_RPS = '0;
  logic        DIR_RQ = 1'b1;
  logic [7:0]  KP = '0;
  logic [7:0]  KI = '0;
  logic [15:0] MOTOR_FB_RPS = '0;
  logic [7:0]  MOTOR_DC;
  logic        DIR_SEL_RQ;
  logic        BUSY_REVERSE;

  pi_speed_regulator #(.CLOCK_HZ(1000), .UPDATE_HZ(100), .ZERO_UPDATES(2)) dut (
    .CLK(CLK), .RESET(RESET), .ENABLE(ENABLE), .SETPOINT_RPS(SETPOINT_RPS),
    .DIR_RQ(DIR_RQ), .KP(KP), .KI(KI), .MOTOR_FB_RPS(MOTOR_FB_RPS),
    .MOTOR_DC(MOTOR_DC), .DIR_SEL_RQ(DIR_SEL_RQ), .BUSY_REVERSE(BUSY_REVERSE)
  );

  always #5 CLK = ~CLK;

  // Edges since reset release; inputs are latched on edges where ecnt%10==0
  int ecnt;
  always @(posedge CLK or negedge RESET) begin
    if (!RESET) ecnt <= 0;
    else        ecnt <= ecnt + 1;
  end

  typedef struct { logic [7:0] dc; logic dir; logic busy; } exp_t;
  exp_t sb[$];
  exp_t e;

  int checks = 0;
  int errors = 0;

  int m_integ;
  bit m_dir;
  bit m_brake;
  int m_zc;

  task automatic model_reset();
    m_integ = 0; m_dir = 1'b1; m_brake = 1'b0; m_zc = 0;
    sb.delete();
  endtask

  task automatic model_push();
    int sp, fb, err, it, u;
    exp_t r;
    sp = SETPOINT_RPS; fb = MOTOR_FB_RPS;
    err = sp - fb;
    r.dc = 8'd0;
    if (!ENABLE) begin
      m_integ = 0; m_brake = 1'b0; m_zc = 0;
      if (DIR_RQ != m_dir && fb == 0) m_dir = DIR_RQ;
    end else if (m_brake) begin
      m_integ = 0;
      if (DIR_RQ == m_dir) begin
        m_brake = 1'b0; m_zc = 0;
      end else if (fb == 0) begin
        m_zc++;
        if (m_zc == 2) begin m_dir = DIR_RQ; m_brake = 1'b0; m_zc = 0; end
      end else begin
        m_zc = 0;
      end
    end else if (DIR_RQ != m_dir) begin
      m_brake = 1'b1; m_integ = 0; m_zc = 0;
    end else begin
      it = m_integ + err * int'(KI);
      u = (err * int'(KP) + it) >>> 4;
      r.dc = (u < 0) ? 8'd0 : (u > 255) ? 8'd255 : 8'(u);
      if (!((u > 255 && err > 0) || (u < 0 && err < 0)))
        m_integ = (it < 0) ? 0 : (it > 4080) ? 4080 : it;
    end
    r.dir = m_dir;
    r.busy = m_brake;
    sb.push_back(r);
  endtask

  task automatic wait_phase(input int ph);
    int n = 0;
    do begin
      @(posedge CLK); #1; n++;
    end while ((ecnt % 10) != ph && n < 25);
    if ((ecnt % 10) != ph) begin
      checks++; errors++;
      $display("FAIL wait_phase: reached phase %0d, required %0d", ecnt % 10, ph);
    end
  endtask

  task automatic latch_tick();
    wait_phase(0);
    model_push();
  endtask

  task automatic apply(input int sp, input int fb, input int kp, input int ki,
                       input bit dir, input bit en);
    SETPOINT_RPS = 16'(sp); MOTOR_FB_RPS = 16'(fb);
    KP = 8'(kp); KI = 8'(ki); DIR_RQ = dir; ENABLE = en;
  endtask

  task automatic test_reset();
    repeat (3) @(posedge CLK);
    #1;
    checks += 3;
    if (MOTOR_DC !== 8'd0) begin errors++; $display("FAIL reset_dc: got %0d expected 0", MOTOR_DC); end
    if (DIR_SEL_RQ !== 1'b1) begin errors++; $display("FAIL reset_dir: got %b expected 1", DIR_SEL_RQ); end
    if (BUSY_REVERSE !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", BUSY_REVERSE); end
    model_reset();
    @(negedge CLK);
    RESET = 1'b1;
  endtask

  task automatic test_first_update();
    apply(20, 0, 8'h10, 0, 1'b1, 1'b1);
    latch_tick();
    wait_phase(2);
    checks++;
    if (MOTOR_DC !== 8'd0) begin errors++; $display("FAIL first_early: got %0d expected 0", MOTOR_DC); end
    wait_phase(3);
    e = sb.pop_front();
    checks += 3;
    if (MOTOR_DC !== e.dc) begin errors++; $display("FAIL first_dc: got %0d expected %0d", MOTOR_DC, e.dc); end
    if (DIR_SEL_RQ !== e.dir) begin errors++; $display("FAIL first_dir: got %b expected %b", DIR_SEL_RQ, e.dir); end
    if (BUSY_REVERSE !== e.busy) begin errors++; $display("FAIL first_busy: got %b expected %b", BUSY_REVERSE, e.busy); end
  endtask

  task automatic run_table(input string nm, input int n, input int sp[], input int fb[],
                           input int kp[], input int ki[], input bit dir[], input bit en[]);
    for (int i = 0; i < n; i++) begin
      apply(sp[i], fb[i], kp[i], ki[i], dir[i], en[i]);
      latch_tick();
      wait_phase(3);
      e = sb.pop_front();
      checks += 3;
      if (MOTOR_DC !== e.dc) begin errors++; $display("FAIL %s[%0d] dc: got %0d expected %0d", nm, i, MOTOR_DC, e.dc); end
      if (DIR_SEL_RQ !== e.dir) begin errors++; $display("FAIL %s[%0d] dir: got %b expected %b", nm, i, DIR_SEL_RQ, e.dir); end
      if (BUSY_REVERSE !== e.busy) begin errors++; $display("FAIL %s[%0d] busy: got %b expected %b", nm, i, BUSY_REVERSE, e.busy); end
    end
  endtask

  task automatic test_saturation();
    run_table("sat", 2, '{300, 300}, '{0, 310}, '{16, 16}, '{0, 0}, '{1, 1}, '{1, 1});
    checks++;
    if (MOTOR_DC !== 8'd0) begin errors++; $display("FAIL sat_nowrap: got %0d expected 0", MOTOR_DC); end
  endtask

  task automatic test_integral();
    run_table("integ", 7, '{5, 5, 5, 1000, 1000, 1000, 0}, '{0, 0, 0, 0, 0, 0, 0},
              '{0, 0, 0, 0, 0, 0, 0}, '{16, 16, 16, 16, 16, 16, 16},
              '{1, 1, 1, 1, 1, 1, 1}, '{1, 1, 1, 1, 1, 1, 1});
    checks++;
    if (MOTOR_DC !== 8'd15) begin errors++; $display("FAIL integ_fall: got %0d expected 15", MOTOR_DC); end
  endtask

  task automatic test_reversal();
    run_table("rev", 10, '{0, 100, 100, 100, 100, 100, 100, 100, 100, 100},
              '{0, 0, 10, 0, 3, 0, 0, 0, 0, 0},
              '{16, 16, 16, 16, 16, 16, 16, 16, 16, 16}, '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0},
              '{1, 1, 0, 0, 0, 0, 0, 0, 1, 0}, '{0, 1, 1, 1, 1, 1, 1, 1, 1, 1});
    run_table("rev_after", 1, '{100}, '{0}, '{16}, '{0}, '{0}, '{1});
  endtask

  task automatic test_enable();
    run_table("en", 10, '{40, 40, 40, 40, 40, 0, 0, 0, 0, 0},
              '{0, 0, 0, 0, 0, 5, 0, 5, 5, 0},
              '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0}, '{16, 16, 16, 16, 16, 16, 16, 16, 16, 16},
              '{0, 0, 0, 0, 0, 1, 1, 0, 0, 0}, '{1, 1, 0, 1, 1, 0, 0, 0, 1, 1});
    run_table("en_tail", 1, '{0}, '{0}, '{0}, '{16}, '{0}, '{1});
  endtask

  task automatic test_mid_pipeline();
    apply(50, 0, 16, 0, m_dir, 1'b1);
    latch_tick();
    wait_phase(1);
    apply(999, 7, 0, 0, m_dir, 1'b1);
    wait_phase(3);
    e = sb.pop_front();
    checks += 2;
    if (MOTOR_DC !== e.dc) begin errors++; $display("FAIL midpipe_dc: got %0d expected %0d", MOTOR_DC, e.dc); end
    if (MOTOR_DC !== 8'd50) begin errors++; $display("FAIL midpipe_abs: got %0d expected 50", MOTOR_DC); end
  endtask

  task automatic test_async_reset();
    bit stale;
    run_table("pre_rst", 1, '{80}, '{0}, '{16}, '{0}, '{m_dir}, '{1});
    apply(200, 0, 16, 0, m_dir, 1'b1);
    latch_tick();
    wait_phase(2);
    RESET = 1'b0;
    #1;
    checks += 3;
    if (MOTOR_DC !== 8'd0) begin errors++; $display("FAIL arst_dc: got %0d expected 0", MOTOR_DC); end
    if (DIR_SEL_RQ !== 1'b1) begin errors++; $display("FAIL arst_dir: got %b expected 1", DIR_SEL_RQ); end
    if (BUSY_REVERSE !== 1'b0) begin errors++; $display("FAIL arst_busy: got %b expected 0", BUSY_REVERSE); end
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    DIR_RQ = 1'b1;
    model_reset();
    RESET = 1'b1;
    stale = 1'b0;
    while (ecnt < 12) begin
      @(posedge CLK); #1;
      if (MOTOR_DC !== 8'd0) stale = 1'b1;
    end
    checks++;
    if (stale) begin errors++; $display("FAIL arst_stale: got nonzero duty before first update, expected 0"); end
    run_table("post_rst", 1, '{200}, '{0}, '{16}, '{0}, '{1}, '{1});
  endtask

  initial begin
    test_reset();
    test_first_update();
    test_saturation();
    test_integral();
    test_reversal();
    test_enable();
    test_mid_pipeline();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
